issue_scoreboard: RTL
=====================

// Module: issue_scoreboard
// PURPOSE
//   Dual-issue dispatch stage directly upstream of the dual-port register file.
//   Takes an in-order pair of decoded instructions (slot0 older), blocks RAW/WAW hazards
//   with a per-register busy scoreboard, and registers the issued pair.
//   The registered pair drives regfile read enables/addresses and the execute-stage payload.
//   Busy bits are set at issue and cleared by the two writeback ports.
// PARAMETERS
//   NREG  32  architectural registers (r0 hardwired zero, never busy)
//   AW    5   register address width, clog2(NREG)
//   PW    64  opaque per-slot payload width (pc, opcode, imm), passed through
// PORTS
//   clk             in   1        clock, all state on rising edge
//   rst_n           in   1        asynchronous active-low reset
//   flush           in   1        pipeline flush (branch mispredict / exception)
//   in_valid        in   [1:0]    slot i holds an instruction
//   in_rs1_en       in   [1:0]    slot i reads rs1
//   in_rs1          in   [1:0][AW-1:0]  rs1 address per slot
//   in_rs2_en       in   [1:0]    slot i reads rs2
//   in_rs2          in   [1:0][AW-1:0]  rs2 address per slot
//   in_rd_we        in   [1:0]    slot i writes rd
//   in_rd           in   [1:0][AW-1:0]  rd address per slot
//   in_payload      in   [1:0][PW-1:0]  pass-through payload
//   in_accept       out  [1:0]    slot i consumed this cycle (combinational)
//   wb_en           in   [1:0]    writeback port i retires a write
//   wb_addr         in   [1:0][AW-1:0]  writeback register address
//   out_ready       in   1        execute stage accepts the registered pair
//   out_valid       out  [1:0]    registered slot valid
//   out_rd_we       out  [1:0]    registered rd write enable
//   out_rd          out  [1:0][AW-1:0]  registered rd
//   out_payload     out  [1:0][PW-1:0]  registered payload
//   reg1_read_en    out  [1:0]    = out_valid & registered rs1_en
//   reg1_read_addr  out  [1:0][AW-1:0]  registered rs1
//   reg2_read_en    out  [1:0]    = out_valid & registered rs2_en
//   reg2_read_addr  out  [1:0][AW-1:0]  registered rs2
//   stall_cnt       out  16       saturating count of slot0 dispatch stalls
// BEHAVIOUR
//   Reset: busy[] = 0, all out_* / reg*_read_* = 0, stall_cnt = 0.
//   Advance: adv = ~|out_valid | out_ready. If !adv or flush: in_accept = 2'b00.
//   free(r) = (r==0) | ~busy[r] | (wb_en[0]&wb_addr[0]==r) | (wb_en[1]&wb_addr[1]==r).
//   ok0 = in_valid[0] & (~rs1_en|free(rs1)) & (~rs2_en|free(rs2)) & (~rd_we|free(rd)).
//   ok1 = same for slot1 & ok0 & no RAW vs slot0 (slot0 rd_we, rd0!=0, rd0 == an enabled
//     rs of slot1) & no WAW (both rd_we, rd0==rd1!=0). Slot1 is never accepted without slot0.
//   in_accept = {ok1,ok0} & {2{adv & ~flush}}. Upstream shifts slot1->slot0 on accept 01.
//   On adv & ~flush: output regs load accepted slots (out_valid = in_accept), else hold.
//   Latency: accepted instruction appears on out_*/reg*_read_* exactly 1 cycle later.
//   Busy update each cycle: clear wb_addr bits, then set accepted rd (rd_we, rd!=0);
//     set wins over clear for the same register in the same cycle. busy[0] stays 0.
//   flush: next cycle busy[] = 0 and out_valid = 0 (overrides wb/set); stall_cnt unchanged.
//   stall_cnt += 1 when in_valid[0] & ~in_accept[0] & ~flush; holds at 16'hFFFF.
//   Reset mid-operation clears everything asynchronously; no partial state survives.
// TESTING
//   Independent pair (r1<=r2+r3, r4<=r5+r6), out_ready=1 -> in_accept=11, out_valid=11 next
//     cycle, reg1_read_addr={5,2}, busy[1]=busy[4]=1.
//   Intra-pair RAW (r1<=..., r7<=r1+r2) -> in_accept=01; after shift, slot0 stalls until
//     wb_en[0] with wb_addr=1, then is accepted in that same cycle.
//   WAW pair both rd=r9 -> accept 01; rd=r0 in both slots -> accept 11, busy[0] stays 0.
//   out_ready=0 with out_valid=11 -> in_accept=00, outputs held, stall_cnt increments per cycle.
//   Issue r3 writer while wb clears r3 same cycle -> busy[3]=1 after edge (set wins).
//   flush with busy[5]=1 and out_valid=11 -> next cycle busy=0, out_valid=00; stall_cnt
//     saturates at FFFF after 65535+ stalled cycles.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Dual-issue dispatch stage: in-order pair issue gated by a per-register busy scoreboard,
// with a registered output pair feeding the register file read ports and execute stage.
module issue_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int PW   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [1:0]           in_valid,
    input  logic [1:0]           in_rs1_en,
    input  logic [1:0][AW-1:0]   in_rs1,
    input  logic [1:0]           in_rs2_en,
    input  logic [1:0][AW-1:0]   in_rs2,
    input  logic [1:0]           in_rd_we,
    input  logic [1:0][AW-1:0]   in_rd,
    input  logic [1:0][PW-1:0]   in_payload,
    output logic [1:0]           in_accept,
    input  logic [1:0]           wb_en,
    input  logic [1:0][AW-1:0]   wb_addr,
    input  logic                 out_ready,
    output logic [1:0]           out_valid,
    output logic [1:0]           out_rd_we,
    output logic [1:0][AW-1:0]   out_rd,
    output logic [1:0][PW-1:0]   out_payload,
    output logic [1:0]           reg1_read_en,
    output logic [1:0][AW-1:0]   reg1_read_addr,
    output logic [1:0]           reg2_read_en,
    output logic [1:0][AW-1:0]   reg2_read_addr,
    output logic [15:0]          stall_cnt
);

    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_free;
    logic [NREG-1:0]       w_busy_nxt;
    logic                  w_adv;
    logic                  w_go;
    logic                  w_raw;
    logic                  w_waw;
    logic [1:0]            w_ok;
    logic [1:0]            r_valid_p1;
    logic [1:0]            r_rd_we_p1;
    logic [1:0][AW-1:0]    r_rd_p1;
    logic [1:0][PW-1:0]    r_payload_p1;
    logic [1:0]            r_rs1_en_p1;
    logic [1:0][AW-1:0]    r_rs1_p1;
    logic [1:0]            r_rs2_en_p1;
    logic [1:0][AW-1:0]    r_rs2_p1;
    logic [15:0]           r_stall_cnt;

    function automatic logic slot_ok(input logic v, input logic rs1_en, input logic [AW-1:0] rs1,
                                     input logic rs2_en, input logic [AW-1:0] rs2,
                                     input logic rd_we, input logic [AW-1:0] rd,
                                     input logic [NREG-1:0] fr);
        return v && (!rs1_en || fr[rs1]) && (!rs2_en || fr[rs2]) && (!rd_we || fr[rd]);
    endfunction

    // A register retiring on either writeback port this cycle is already usable.
    always_comb begin
        w_free = '0;
        for (int r = 0; r < NREG; r++) begin
            w_free[r] = (r == 0) || !r_busy[r] ||
                        (wb_en[0] && (wb_addr[0] == AW'(r))) ||
                        (wb_en[1] && (wb_addr[1] == AW'(r)));
        end
    end

    assign w_adv = ~|r_valid_p1 | out_ready;
    assign w_go  = w_adv & ~flush;
    assign w_raw = in_rd_we[0] && (in_rd[0] != '0) &&
                   ((in_rs1_en[1] && (in_rs1[1] == in_rd[0])) ||
                    (in_rs2_en[1] && (in_rs2[1] == in_rd[0])));
    assign w_waw = in_rd_we[0] && in_rd_we[1] && (in_rd[0] == in_rd[1]) && (in_rd[0] != '0);

    always_comb begin
        w_ok    = '0;
        w_ok[0] = slot_ok(in_valid[0], in_rs1_en[0], in_rs1[0], in_rs2_en[0], in_rs2[0],
                          in_rd_we[0], in_rd[0], w_free);
        w_ok[1] = w_ok[0] && !w_raw && !w_waw &&
                  slot_ok(in_valid[1], in_rs1_en[1], in_rs1[1], in_rs2_en[1], in_rs2[1],
                          in_rd_we[1], in_rd[1], w_free);
    end

    assign in_accept = w_ok & {2{w_go}};

    // Writeback clears first so a same-cycle issue to that register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < 2; i++) begin
            if (wb_en[i]) w_busy_nxt[wb_addr[i]] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (in_accept[i] && in_rd_we[i]) w_busy_nxt[in_rd[i]] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_busy <= '0;
        else if (flush) r_busy <= '0;
        else            r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid[0] && !in_accept[0] && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // ---- issue register boundary (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_p1   <= '0;
            r_rd_we_p1   <= '0;
            r_rd_p1      <= '0;
            r_payload_p1 <= '0;
            r_rs1_en_p1  <= '0;
            r_rs1_p1     <= '0;
            r_rs2_en_p1  <= '0;
            r_rs2_p1     <= '0;
        end else if (flush) begin
            r_valid_p1   <= '0;
        end else if (w_adv) begin
            r_valid_p1   <= in_accept;
            r_rd_we_p1   <= in_rd_we;
            r_rd_p1      <= in_rd;
            r_payload_p1 <= in_payload;
            r_rs1_en_p1  <= in_rs1_en;
            r_rs1_p1     <= in_rs1;
            r_rs2_en_p1  <= in_rs2_en;
            r_rs2_p1     <= in_rs2;
        end
    end

    assign out_valid      = r_valid_p1;
    assign out_rd_we      = r_rd_we_p1;
    assign out_rd         = r_rd_p1;
    assign out_payload    = r_payload_p1;
    assign reg1_read_en   = r_valid_p1 & r_rs1_en_p1;
    assign reg1_read_addr = r_rs1_p1;
    assign reg2_read_en   = r_valid_p1 & r_rs2_en_p1;
    assign reg2_read_addr = r_rs2_p1;
    assign stall_cnt      = r_stall_cnt;

endmodule
